// File: rtl/branch_pkg.sv
// branch_pkg: shared types for the branch resolution slice.
//   pred_entry_t    - one buffered fetch-time prediction {pc, pred_taken, pred_next}
//   resolve_state_t - resolver FSM states (RUN, RECOVER)
//   fall_through()  - sequential next PC (pc + 4, wraps modulo 2^BR_ADDR_W)
package branch_pkg;

    localparam int unsigned BR_ADDR_W = 32;

    typedef struct packed {
        logic [BR_ADDR_W-1:0] pc;
        logic                 pred_taken;
        logic [BR_ADDR_W-1:0] pred_next;
    } pred_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } resolve_state_t;

    function automatic logic [BR_ADDR_W-1:0] fall_through(input logic [BR_ADDR_W-1:0] pc);
        return pc + BR_ADDR_W'(4);
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// pred_fifo: synchronous in-order FIFO of pred_entry_t.
// Parameters: DEPTH (power of two), PTR_BITS = log2(DEPTH).
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   push, din       - enqueue din; accepted when not full, or when full with a pop
//   pop             - dequeue head; ignored when empty
//   flush           - empties the queue, overriding push and pop in that cycle
//   full, empty     - combinational from the occupancy counter
//   head            - oldest entry, valid when !empty
module pred_fifo
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PTR_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  pred_entry_t din,
    input  logic        pop,
    input  logic        flush,
    output logic        full,
    output logic        empty,
    output pred_entry_t head
);

    pred_entry_t         mem_q [DEPTH];
    pred_entry_t         mem_d [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]   count_q, count_d;
    logic                do_push;
    logic                do_pop;

    assign full  = (count_q == (PTR_BITS+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: buffers fetch-time predictions, resolves them at execute,
// trains the predictor and redirects the front end on a mispredict.
// Optional feature macro: BRANCH_STATS_EN (branch / mispredict counters).
// Parameters: ADDRESS_WIDTH (must equal branch_pkg::BR_ADDR_W), DEPTH, PTR_BITS.
// Ports:
//   clk, reset                              - clock, synchronous active-high reset
//   fetch_push, pcF, branch_predictF,
//   branch_targetF, full                    - fetch-side prediction enqueue / stall
//   exec_valid, pcE, is_branchE,
//   actual_takenE, actual_targetE           - execute-side resolution
//   branch_valid, branch_taken, targetE     - registered predictor training port
//   redirect_valid, redirect_pc             - front-end restart request
//   order_error                             - sticky queue/execute ordering fault
//   branch_count, mispredict_count          - saturating statistics
module branch_resolve
    import branch_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned PTR_BITS      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_push,
    input  logic [ADDRESS_WIDTH-1:0] pcF,
    input  logic                     branch_predictF,
    input  logic [ADDRESS_WIDTH-1:0] branch_targetF,
    output logic                     full,
    input  logic                     exec_valid,
    input  logic [ADDRESS_WIDTH-1:0] pcE,
    input  logic                     is_branchE,
    input  logic                     actual_takenE,
    input  logic [ADDRESS_WIDTH-1:0] actual_targetE,
    output logic                     branch_valid,
    output logic                     branch_taken,
    output logic [ADDRESS_WIDTH-1:0] targetE,
    output logic                     redirect_valid,
    output logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     order_error,
    output logic [31:0]              branch_count,
    output logic [31:0]              mispredict_count
);

    resolve_state_t           state_q, state_d;
    logic                     branch_valid_q, branch_valid_d;
    logic                     branch_taken_q, branch_taken_d;
    logic [ADDRESS_WIDTH-1:0] target_q, target_d;
    logic [ADDRESS_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                     order_error_q, order_error_d;

    pred_entry_t              fifo_din;
    pred_entry_t              head;
    logic                     empty;
    logic                     in_run;
    logic                     pop_ok;
    logic                     push_req;
    logic                     mispredict;
    logic [ADDRESS_WIDTH-1:0] actual_next;
    logic                     unused_pred_taken;

    // Direction is implied by pred_next, so the stored flag is not consulted.
    assign unused_pred_taken = head.pred_taken;

    pred_fifo #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (fifo_din),
        .pop   (pop_ok),
        .flush (mispredict),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_comb begin
        fifo_din    = '{pc: pcF, pred_taken: branch_predictF, pred_next: branch_targetF};
        in_run      = (state_q == RUN);
        pop_ok      = in_run && exec_valid && !empty;
        push_req    = in_run && fetch_push;
        actual_next = (is_branchE && actual_takenE) ? actual_targetE : fall_through(pcE);
        // Comparing full next-PC covers wrong direction, wrong target and
        // a taken prediction on a non-branch in one check.
        mispredict  = pop_ok && (head.pred_next != actual_next);

        state_d        = state_q;
        redirect_pc_d  = redirect_pc_q;
        order_error_d  = order_error_q;
        branch_valid_d = 1'b0;
        branch_taken_d = branch_taken_q;
        target_d       = target_q;

        case (state_q)
            RUN:     if (mispredict) state_d = RECOVER;
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase

        if (mispredict) begin
            redirect_pc_d = actual_next;
        end

        if (in_run && exec_valid && empty) begin
            order_error_d = 1'b1;
        end
        if (pop_ok && (head.pc != pcE)) begin
            order_error_d = 1'b1;
        end

        if (pop_ok && is_branchE) begin
            branch_valid_d = 1'b1;
            branch_taken_d = actual_takenE;
            target_d       = actual_targetE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            branch_valid_q <= 1'b0;
            branch_taken_q <= 1'b0;
            target_q       <= '0;
            redirect_pc_q  <= '0;
            order_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            branch_valid_q <= branch_valid_d;
            branch_taken_q <= branch_taken_d;
            target_q       <= target_d;
            redirect_pc_q  <= redirect_pc_d;
            order_error_q  <= order_error_d;
        end
    end

    assign branch_valid   = branch_valid_q;
    assign branch_taken   = branch_taken_q;
    assign targetE        = target_q;
    assign redirect_valid = (state_q == RECOVER);
    assign redirect_pc    = redirect_pc_q;
    assign order_error    = order_error_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (pop_ok && is_branchE && (branch_count_q != '1)) begin
            branch_count_d = branch_count_q + 32'd1;
        end
        if (mispredict && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed plus randomized bench for branch_resolve with a
// queue-based reference model of the prediction/resolution behaviour.
module tb_branch_resolve;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        fetch_push;
    logic [31:0] pcF;
    logic        branch_predictF;
    logic [31:0] branch_targetF;
    logic        full;
    logic        exec_valid;
    logic [31:0] pcE;
    logic        is_branchE;
    logic        actual_takenE;
    logic [31:0] actual_targetE;
    logic        branch_valid;
    logic        branch_taken;
    logic [31:0] targetE;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        order_error;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_resolve #(
        .ADDRESS_WIDTH (32),
        .DEPTH         (4),
        .PTR_BITS      (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_push       (fetch_push),
        .pcF              (pcF),
        .branch_predictF  (branch_predictF),
        .branch_targetF   (branch_targetF),
        .full             (full),
        .exec_valid       (exec_valid),
        .pcE              (pcE),
        .is_branchE       (is_branchE),
        .actual_takenE    (actual_takenE),
        .actual_targetE   (actual_targetE),
        .branch_valid     (branch_valid),
        .branch_taken     (branch_taken),
        .targetE          (targetE),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .order_error      (order_error),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] pn;
    } ment_t;

    ment_t       mq[$];
    bit          recovering;
    logic        e_bv, e_bt, e_ord;
    logic [31:0] e_tgt, e_rpc, e_bc, e_mc;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_tick();
        ment_t       h;
        bit          pop;
        bit          was_full;
        bit          mis;
        logic [31:0] anext;
        if (reset) begin
            mq.delete();
            recovering = 0;
            e_bv = 0; e_bt = 0; e_tgt = 0; e_rpc = 0; e_ord = 0; e_bc = 0; e_mc = 0;
        end else if (recovering) begin
            recovering = 0;
            e_bv = 0;
        end else begin
            pop      = exec_valid && (mq.size() != 0);
            was_full = (mq.size() == DEPTH);
            mis      = 0;
            e_bv     = 0;
            if (exec_valid && mq.size() == 0) e_ord = 1;
            if (pop) begin
                h     = mq[0];
                anext = (is_branchE && actual_takenE) ? actual_targetE : pcE + 32'd4;
                mis   = (h.pn != anext);
                if (h.pc != pcE) e_ord = 1;
                if (is_branchE) begin
                    e_bv = 1; e_bt = actual_takenE; e_tgt = actual_targetE;
                end
`ifdef BRANCH_STATS_EN
                if (is_branchE && e_bc != 32'hFFFF_FFFF) e_bc++;
                if (mis && e_mc != 32'hFFFF_FFFF) e_mc++;
`endif
                if (mis) e_rpc = anext;
            end
            if (mis) begin
                mq.delete();
                recovering = 1;
            end else begin
                if (pop) void'(mq.pop_front());
                if (fetch_push && (!was_full || pop))
                    mq.push_back('{pc: pcF, pt: branch_predictF, pn: branch_targetF});
            end
        end
    endtask

    task automatic check_all();
        chk("full",             {31'd0, full},           {31'd0, mq.size() == DEPTH});
        chk("branch_valid",     {31'd0, branch_valid},   {31'd0, e_bv});
        chk("branch_taken",     {31'd0, branch_taken},   {31'd0, e_bt});
        chk("targetE",          targetE,                 e_tgt);
        chk("redirect_valid",   {31'd0, redirect_valid}, {31'd0, recovering});
        chk("redirect_pc",      redirect_pc,             e_rpc);
        chk("order_error",      {31'd0, order_error},    {31'd0, e_ord});
        chk("branch_count",     branch_count,            e_bc);
        chk("mispredict_count", mispredict_count,        e_mc);
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        reset = 0; fetch_push = 0; exec_valid = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] pn);
        fetch_push = 1; pcF = pc; branch_predictF = pt; branch_targetF = pn;
    endtask

    task automatic pop(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tg);
        exec_valid = 1; pcE = pc; is_branchE = br; actual_takenE = tk; actual_targetE = tg;
    endtask

    task automatic rand_inputs(input bit gate_exec);
        logic [31:0] r;
        reset           = 0;
        fetch_push      = ($urandom_range(0, 2) != 0);
        pcF             = $urandom & 32'hFFFF_FFFC;
        branch_predictF = $urandom_range(0, 1) == 1;
        r               = $urandom & 32'hFFFF_FFFC;
        branch_targetF  = branch_predictF ? r : pcF + 32'd4;
        exec_valid      = ($urandom_range(0, 2) != 0) &&
                          (!gate_exec || mq.size() != 0 || recovering);
        if (mq.size() != 0 && $urandom_range(0, 9) < 7) begin
            pcE            = mq[0].pc;
            is_branchE     = 1;
            actual_takenE  = mq[0].pt;
            actual_targetE = mq[0].pt ? mq[0].pn : ($urandom & 32'hFFFF_FFFC);
        end else begin
            pcE            = (mq.size() != 0) ? mq[0].pc : ($urandom & 32'hFFFF_FFFC);
            is_branchE     = $urandom_range(0, 1) == 1;
            actual_takenE  = $urandom_range(0, 1) == 1;
            actual_targetE = $urandom & 32'hFFFF_FFFC;
        end
    endtask

    initial begin
        reset = 1; fetch_push = 0; pcF = 0; branch_predictF = 0; branch_targetF = 0;
        exec_valid = 0; pcE = 0; is_branchE = 0; actual_takenE = 0; actual_targetE = 0;
        step();
        step();
        chk("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);

        // Correctly predicted not-taken branch
        idle(); push(32'h100, 0, 32'h104); step();
        idle(); pop(32'h100, 1, 0, 32'h180); step();
        chk("t1_branch_valid", {31'd0, branch_valid}, 32'd1);
        chk("t1_no_redirect",  {31'd0, redirect_valid}, 32'd0);
        idle(); step();

        // Wrong direction: flush, redirect, push during recovery dropped
        idle(); push(32'h200, 0, 32'h204); step();
        idle(); pop(32'h200, 1, 1, 32'h300); push(32'h204, 0, 32'h208); step();
        chk("t2_redirect_pc", redirect_pc, 32'h300);
        idle(); push(32'h300, 0, 32'h304); step();
        chk("t2_recover_done", {31'd0, redirect_valid}, 32'd0);
        idle(); step();

        // Wrong target on a predicted-taken branch
        idle(); push(32'h400, 1, 32'h480); step();
        idle(); pop(32'h400, 1, 1, 32'h500); step();
        chk("t3_redirect_pc", redirect_pc, 32'h500);
        chk("t3_targetE",     targetE,     32'h500);
        idle(); step();

        // Fill, overflow drop, push+pop while full, drain
        for (int i = 0; i < 4; i++) begin
            idle(); push(32'h1000 + 32'(4 * i), 0, 32'h1004 + 32'(4 * i)); step();
        end
        chk("t4_full", {31'd0, full}, 32'd1);
        idle(); push(32'h2000, 0, 32'h2004); step();
        idle(); push(32'h1010, 0, 32'h1014); pop(32'h1000, 0, 0, 32'h0); step();
        chk("t4_full_after_pushpop", {31'd0, full}, 32'd1);
        for (int i = 1; i < 5; i++) begin
            idle(); pop(32'h1000 + 32'(4 * i), 1, 0, 32'h9000); step();
        end
        chk("t4_order_ok", {31'd0, order_error}, 32'd0);

        // Randomized traffic, with a reset landing mid-stream
        for (int i = 0; i < 300; i++) begin
            rand_inputs(1);
            if (i == 150) reset = 1;
            step();
        end

        // Ordering faults: pop from empty, then head PC mismatch
        idle(); step(); step();
        while (mq.size() != 0 || recovering) begin
            idle(); pop(mq.size() != 0 ? mq[0].pc : 32'h0, 0, 0, 32'h0);
            if (recovering) exec_valid = 0;
            pcE = (mq.size() != 0) ? mq[0].pc : 32'h0;
            step();
        end
        idle(); pop(32'h40, 0, 0, 32'h0); step();
        chk("t5_empty_pop_error", {31'd0, order_error}, 32'd1);
        idle(); reset = 1; step();
        idle(); push(32'h14, 0, 32'h18); step();
        idle(); pop(32'h10, 0, 0, 32'h0); step();
        chk("t5_head_mismatch", {31'd0, order_error}, 32'd1);

        // order_error must stay set through further traffic
        for (int i = 0; i < 60; i++) begin
            rand_inputs(0);
            step();
        end
        chk("t5_sticky", {31'd0, order_error}, 32'd1);
        idle(); reset = 1; step();
        chk("t5_cleared", {31'd0, order_error}, 32'd0);
        idle(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
